// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates 3-bit tags at dispatch, captures CDB results,
// retires the oldest completed entry per cycle and forwards finished results to operand reads.
module reorder_buffer #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alloc_req,
  input  logic [4:0]  alloc_dest,
  output logic        alloc_ready,
  output logic [2:0]  alloc_tag,
  input  logic        cdb_valid,
  input  logic [2:0]  cdb_tag,
  input  logic [31:0] cdb_data,
  input  logic        flush,
  input  logic [2:0]  rd_tag_a,
  input  logic [2:0]  rd_tag_b,
  output logic        rd_ready_a,
  output logic        rd_ready_b,
  output logic [31:0] rd_data_a,
  output logic [31:0] rd_data_b,
  output logic        commit_valid,
  output logic        commit_load,
  output logic [4:0]  commit_dest,
  output logic [31:0] commit_data,
  output logic [2:0]  commit_tag,
  output logic [3:0]  count,
  output logic        empty
);

  localparam logic [3:0] FULL = 4'(DEPTH);

  typedef struct packed {
    logic        busy;
    logic        done;
    logic [4:0]  dest;
    logic [31:0] data;
  } entry_t;

  entry_t      ent_q [DEPTH];
  entry_t      ent_d [DEPTH];
  logic [2:0]  head_q, head_d;
  logic [2:0]  tail_q, tail_d;
  logic [3:0]  count_q, count_d;
  logic        alloc_fire;

  assign alloc_ready  = (count_q != FULL);
  assign alloc_fire   = alloc_req && alloc_ready;
  assign alloc_tag    = tail_q;
  assign count        = count_q;
  assign empty        = (count_q == 4'd0);

  // Commit port is purely combinational from head so the register file writes at the ending edge.
  assign commit_valid = ent_q[head_q].busy && ent_q[head_q].done && !flush;
  assign commit_dest  = ent_q[head_q].dest;
  assign commit_data  = ent_q[head_q].data;
  assign commit_tag   = head_q;
  assign commit_load  = commit_valid && (commit_dest != 5'd0);

  // Stored result first, then same-cycle CDB bypass for a busy entry.
  function automatic logic [32:0] forward(input logic [2:0] tag);
    if (ent_q[tag].done)
      return {1'b1, ent_q[tag].data};
    else if (cdb_valid && (cdb_tag == tag) && ent_q[tag].busy)
      return {1'b1, cdb_data};
    else
      return 33'd0;
  endfunction

  always_comb begin
    {rd_ready_a, rd_data_a} = forward(rd_tag_a);
    {rd_ready_b, rd_data_b} = forward(rd_tag_b);
  end

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
    ent_d   = ent_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_d[i].busy = 1'b0;
        ent_d[i].done = 1'b0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (cdb_valid && ent_q[cdb_tag].busy && !ent_q[cdb_tag].done) begin
        ent_d[cdb_tag].done = 1'b1;
        ent_d[cdb_tag].data = cdb_data;
      end
      if (commit_valid) begin
        ent_d[head_q].busy = 1'b0;
        head_d             = head_q + 3'd1;
      end
      // Tail is never busy when allocation fires, so it cannot collide with capture or commit.
      if (alloc_fire) begin
        ent_d[tail_q].busy = 1'b1;
        ent_d[tail_q].done = 1'b0;
        ent_d[tail_q].dest = alloc_dest;
        tail_d             = tail_q + 3'd1;
      end
      count_d = count_q + {3'd0, alloc_fire} - {3'd0, commit_valid};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: entry storage is reset too, because the commit outputs must read zero out of reset.
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: commits are checked by a scoreboard monitor,
// allocation/forwarding/occupancy by inline checks.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_req;
  logic [4:0]  alloc_dest;
  logic        alloc_ready;
  logic [2:0]  alloc_tag;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        flush;
  logic [2:0]  rd_tag_a, rd_tag_b;
  logic        rd_ready_a, rd_ready_b;
  logic [31:0] rd_data_a, rd_data_b;
  logic        commit_valid, commit_load;
  logic [4:0]  commit_dest;
  logic [31:0] commit_data;
  logic [2:0]  commit_tag;
  logic [3:0]  count;
  logic        empty;

  reorder_buffer dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .alloc_dest(alloc_dest),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .flush(flush),
    .rd_tag_a(rd_tag_a), .rd_tag_b(rd_tag_b),
    .rd_ready_a(rd_ready_a), .rd_ready_b(rd_ready_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .commit_valid(commit_valid), .commit_load(commit_load),
    .commit_dest(commit_dest), .commit_data(commit_data), .commit_tag(commit_tag),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        load;
    logic [2:0]  tag;
    logic [4:0]  dest;
    logic [31:0] data;
  } commit_t;

  commit_t sb_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic sb_push(input logic load, input logic [2:0] tag,
                         input logic [4:0] dest, input logic [31:0] data);
    commit_t e;
    e.load = load; e.tag = tag; e.dest = dest; e.data = data;
    sb_q.push_back(e);
  endtask

  // Monitor: every retirement seen by the DUT must match the next expected commit.
  initial begin
    commit_t act, exp;
    forever begin
      @(negedge clk);
      if (commit_valid) begin
        act = {commit_load, commit_tag, commit_dest, commit_data};
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_commit: got 0x%0h, expected no commit", act);
        end else begin
          exp = sb_q.pop_front();
          check("commit", 64'(act), 64'(exp));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic alloc(input logic [4:0] dest, input logic [2:0] exp_tag);
    alloc_req  = 1'b1;
    alloc_dest = dest;
    smp();
    check("alloc_tag", 64'(alloc_tag), 64'(exp_tag));
    step();
    alloc_req = 1'b0;
  endtask

  task automatic cdb(input logic [2:0] tag, input logic [31:0] data);
    cdb_valid = 1'b1;
    cdb_tag   = tag;
    cdb_data  = data;
    step();
    cdb_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; alloc_req = 1'b0; alloc_dest = '0; cdb_valid = 1'b0; cdb_tag = '0;
    cdb_data = '0; flush = 1'b0; rd_tag_a = '0; rd_tag_b = '0;
    #1 rst = 1'b0;
    #2;
    check("rst_alloc_ready", 64'(alloc_ready), 64'd1);
    check("rst_alloc_tag",   64'(alloc_tag),   64'd0);
    check("rst_empty",       64'(empty),       64'd1);
    check("rst_count",       64'(count),       64'd0);
    check("rst_commit_valid",64'(commit_valid),64'd0);
    check("rst_commit_load", 64'(commit_load), 64'd0);
    check("rst_commit_dest", 64'(commit_dest), 64'd0);
    check("rst_commit_data", 64'(commit_data), 64'd0);
    check("rst_commit_tag",  64'(commit_tag),  64'd0);
    check("rst_rd_ready_a",  64'(rd_ready_a),  64'd0);
    check("rst_rd_data_a",   64'(rd_data_a),   64'd0);
    check("rst_rd_ready_b",  64'(rd_ready_b),  64'd0);
    check("rst_rd_data_b",   64'(rd_data_b),   64'd0);
    step(); step();
    rst = 1'b1;

    // Mid-run asynchronous reset with 5 entries occupied.
    for (int i = 0; i < 5; i++) alloc(5'(i + 1), 3'(i));
    check("pre_rst_count", 64'(count), 64'd5);
    #2 rst = 1'b0;
    #1;
    check("midrst_count",        64'(count),        64'd0);
    check("midrst_empty",        64'(empty),        64'd1);
    check("midrst_alloc_ready",  64'(alloc_ready),  64'd1);
    check("midrst_commit_valid", 64'(commit_valid), 64'd0);
    step();
    rst = 1'b1;

    // Fill to full; the first allocation after reset must get tag 0.
    for (int i = 0; i < 8; i++) alloc(5'(i + 1), 3'(i));
    check("full_count", 64'(count), 64'd8);
    alloc_req = 1'b1; alloc_dest = 5'd9;
    smp();
    check("full_alloc_ready", 64'(alloc_ready), 64'd0);
    step();
    alloc_req = 1'b0;
    check("full_count_hold", 64'(count),     64'd8);
    check("full_tail_hold",  64'(alloc_tag), 64'd0);
    sb_push(1'b1, 3'd0, 5'd1, 32'hAAAA_0000);
    cdb(3'd0, 32'hAAAA_0000);
    smp();
    check("full_commit_valid",      64'(commit_valid), 64'd1);
    check("full_commit_alloc_ready",64'(alloc_ready),  64'd0);
    step();
    check("after_commit_count", 64'(count), 64'd7);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush1_count", 64'(count),      64'd0);
    check("flush1_empty", 64'(empty),      64'd1);
    check("flush1_tail",  64'(alloc_tag),  64'd0);
    check("flush1_head",  64'(commit_tag), 64'd0);

    // Out-of-order completion, in-order retirement.
    alloc(5'd10, 3'd0); alloc(5'd11, 3'd1); alloc(5'd12, 3'd2);
    sb_push(1'b1, 3'd0, 5'd10, 32'h0000_1000);
    sb_push(1'b1, 3'd1, 5'd11, 32'h0000_1001);
    sb_push(1'b1, 3'd2, 5'd12, 32'h0000_1002);
    cdb(3'd2, 32'h0000_1002);
    cdb(3'd1, 32'h0000_1001);
    cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_data = 32'h0000_1000;
    smp();
    check("ooo_no_bypass", 64'(commit_valid), 64'd0);
    step();
    cdb_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      smp();
      check("ooo_commit_tag", 64'(commit_tag), 64'(k));
      step();
    end
    check("ooo_empty", 64'(empty), 64'd1);

    // Forwarding: same-cycle CDB bypass, then stored value.
    alloc(5'd7, 3'd3);
    sb_push(1'b1, 3'd3, 5'd7, 32'h1234_5678);
    cdb_valid = 1'b1; cdb_tag = 3'd3; cdb_data = 32'h1234_5678;
    rd_tag_a = 3'd3; rd_tag_b = 3'd4;
    smp();
    check("fwd_bypass_ready", 64'(rd_ready_a), 64'd1);
    check("fwd_bypass_data",  64'(rd_data_a),  64'h1234_5678);
    check("fwd_idle_ready",   64'(rd_ready_b), 64'd0);
    check("fwd_idle_data",    64'(rd_data_b),  64'd0);
    step();
    cdb_valid = 1'b0;
    smp();
    check("fwd_stored_ready", 64'(rd_ready_a), 64'd1);
    check("fwd_stored_data",  64'(rd_data_a),  64'h1234_5678);
    step();

    // Dest x0 retires without a register-file write.
    alloc(5'd0, 3'd4); alloc(5'd9, 3'd5);
    sb_push(1'b0, 3'd4, 5'd0, 32'hDEAD_0004);
    sb_push(1'b1, 3'd5, 5'd9, 32'hBEEF_0005);
    cdb(3'd4, 32'hDEAD_0004);
    cdb_valid = 1'b1; cdb_tag = 3'd5; cdb_data = 32'hBEEF_0005;
    smp();
    check("x0_commit_valid", 64'(commit_valid), 64'd1);
    check("x0_commit_load",  64'(commit_load),  64'd0);
    step();
    cdb_valid = 1'b0;
    step();
    check("x0_count", 64'(count), 64'd0);

    // Wrap-around from head = tail = 6.
    alloc(5'd20, 3'd6); alloc(5'd21, 3'd7); alloc(5'd22, 3'd0); alloc(5'd23, 3'd1);
    sb_push(1'b1, 3'd6, 5'd20, 32'h6666_0006);
    sb_push(1'b1, 3'd7, 5'd21, 32'h7777_0007);
    sb_push(1'b1, 3'd0, 5'd22, 32'h0000_00A0);
    sb_push(1'b1, 3'd1, 5'd23, 32'h1111_0001);
    cdb(3'd6, 32'h6666_0006);
    cdb(3'd7, 32'h7777_0007);
    cdb(3'd0, 32'h0000_00A0);
    cdb(3'd1, 32'h1111_0001);
    step();
    check("wrap_empty", 64'(empty),      64'd1);
    check("wrap_tail",  64'(alloc_tag),  64'd2);
    check("wrap_head",  64'(commit_tag), 64'd2);

    // Flush beats a simultaneous allocation and CDB hit.
    alloc(5'd3, 3'd2); alloc(5'd4, 3'd3);
    cdb(3'd3, 32'h0000_0033);
    flush = 1'b1; alloc_req = 1'b1; alloc_dest = 5'd5;
    cdb_valid = 1'b1; cdb_tag = 3'd2; cdb_data = 32'h0000_0022;
    smp();
    check("flush_no_commit", 64'(commit_valid), 64'd0);
    step();
    flush = 1'b0; alloc_req = 1'b0;
    check("flush_count", 64'(count),     64'd0);
    check("flush_empty", 64'(empty),     64'd1);
    check("flush_tail",  64'(alloc_tag), 64'd0);
    rd_tag_a = 3'd3; rd_tag_b = 3'd2;
    #1;
    check("flush_done_cleared", 64'(rd_ready_a), 64'd0);
    check("flush_busy_cleared", 64'(rd_ready_b), 64'd0);
    step();
    cdb_valid = 1'b0;
    step(); step();
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order retirement buffer for the Tomasulo core, sitting between dispatch, the CDB and the architectural register file. It hands out 3-bit tags at dispatch and captures CDB results against those tags. It retires the oldest completed entry each cycle by driving the register file's write port: load, dest, in and commit_tag. It also answers operand-forwarding queries for tags the register file reports as not valid.

## Interface
- DEPTH, 8: entry count; fixed to 8 because tags are 3 bits wide.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- alloc_req  in  1  dispatch requests an entry this cycle.
- alloc_dest  in  5  destination architectural register of the dispatching instruction.
- alloc_ready  out  1  buffer not full; an allocation is accepted when alloc_req and alloc_ready are both high.
- alloc_tag  out  3  tag assigned to the accepted allocation (current tail index).
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  3  tag of the broadcast result.
- cdb_data  in  32  broadcast result value.
- flush  in  1  synchronous squash of all entries (mispredict).
- rd_tag_a, rd_tag_b  in  3 each  operand tags to forward.
- rd_ready_a, rd_ready_b  out  1 each  the tag's result is available.
- rd_data_a, rd_data_b  out  32 each  the forwarded value.
- commit_valid  out  1  head entry retires this cycle.
- commit_load  out  1  register file write enable; equals commit_valid && commit_dest != 0.
- commit_dest  out  5  destination register of the head entry.
- commit_data  out  32  result of the head entry.
- commit_tag  out  3  tag of the head entry (head index).
- count  out  4  occupied entries, 0..8.
- empty  out  1  count == 0.

## Operation
- Per-entry state: busy, done, dest[4:0], data[31:0].
- Buffer state: head[2:0], tail[2:0], count[3:0]. Head and tail wrap 7 -> 0 naturally.
- **Allocate:** when alloc_req && count != 8:
  - entry[tail] <= {busy=1, done=0, dest=alloc_dest}.
  - tail <= tail+1.
  - alloc_tag = tail, combinationally.
- **CDB capture:** when cdb_valid && entry[cdb_tag].busy && !done, set done=1 and data=cdb_data.
  - A broadcast to a non-busy entry is ignored.
  - A broadcast to an entry that is already done is ignored.
- **Commit:** commit_valid = entry[head].busy && entry[head].done && !flush.
  - On a clock edge with commit_valid: clear entry[head].busy and advance head.
  - Dest x0 entries retire with commit_load=0.
- **Count:** count <= count + accepted_alloc - commit_valid. Simultaneous allocate and commit leaves count unchanged.
- **Forwarding**, per port, combinational:
  - If entry[rd_tag].done: rd_ready=1 and rd_data = stored data.
  - Else if cdb_valid && cdb_tag == rd_tag && entry busy: rd_ready=1 and rd_data = cdb_data (same-cycle bypass).
  - Otherwise rd_ready=0 and rd_data=0.
- **Flush** has priority over every other update: head, tail and count go to 0; every busy and done bit clears; allocation and CDB capture on that edge are dropped.

## Timing
- On reset, all state is cleared and the outputs are:
  - alloc_ready=1, alloc_tag=0, empty=1, count=0.
  - commit_valid=0, commit_load=0, commit_dest=0, commit_data=0, commit_tag=0.
  - rd_ready_*=0, rd_data_*=0.
- Reset asserted mid-operation discards all entries immediately; it does not wait for a clock edge.
- Allocation: tag visible the same cycle; the entry is busy from the next edge.
- CDB to commit: a minimum of 1 cycle. A result captured at edge N can retire in the cycle after edge N; there is no CDB-to-commit bypass.
- At most one allocation and one retirement per cycle.
- Full: alloc_ready is deasserted when count==8, even if a commit occurs in the same cycle (conservative). A request while full is not accepted and has no effect.
- Empty: commit_valid=0, and the commit outputs still reflect entry[head] with busy=0.
- Commit outputs are combinational from head state, so the register file sees load during the retire cycle and writes at the ending edge.

## Test plan
- **Reset:** rst low mid-run with 5 entries occupied -> count=0, empty=1, alloc_ready=1 and commit_valid=0 immediately; the first allocation after release gets alloc_tag=0.
- **Fill/full:** 8 back-to-back allocations with dest 1..8 -> tags 0..7 and count=8. On the 9th request alloc_ready=0 and tail is unchanged. Then CDB tag 0 with data 0xAAAA0000 -> the next cycle shows commit_valid=1, commit_dest=1, commit_data=0xAAAA0000 and commit_tag=0.
- **Out-of-order completion:** allocate tags 0, 1 and 2, then broadcast CDB tags 2, 1, 0 on consecutive cycles -> retirements occur in order 0, 1, 2 on the three cycles after tag 0's capture.
- **Wrap-around:** with head=tail=6 and count=0, allocate 4 entries -> tags 6, 7, 0, 1; complete and retire them all -> head=tail=2 and empty=1.
- **Forwarding:** tag 3 is busy; in the same cycle cdb_tag=3 with cdb_data=0x12345678 and rd_tag_a=3 -> rd_ready_a=1 and rd_data_a=0x12345678; the next cycle still shows rd_ready_a=1 from the stored entry.
- **x0 and flush:** an entry with dest=0 completes -> commit_valid=1 and commit_load=0. Flush asserted together with an allocation and a CDB hit -> count=0 afterwards and no entry is busy.
